// File: rtl/player_attack_multi.sv
// Per-player attack timing engine: N attack types with per-attack total/startup/active frame counts.
// Optional recovery-phase input buffer enabled by defining ATK_INPUT_BUFFER_EN.
module player_attack_multi #(
  parameter int unsigned                  NUM_ATK   = 2,
  parameter int unsigned                  FRAME_W   = 6,
  parameter logic [NUM_ATK*FRAME_W-1:0]   ATK_TOTAL = {6'd26, 6'd18},
  parameter logic [NUM_ATK*FRAME_W-1:0]   ATK_ACT_S = {6'd8,  6'd4 },
  parameter logic [NUM_ATK*FRAME_W-1:0]   ATK_ACT_E = {6'd16, 6'd10},
  localparam int unsigned                 TYPE_W    = $clog2(NUM_ATK + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               SCEN,
  input  logic               attack_enable,
  input  logic [NUM_ATK-1:0] attack_req,
  input  logic               cancel,
  output logic [TYPE_W-1:0]  attack_type,
  output logic [FRAME_W-1:0] attack_frame,
  output logic               attack_busy,
  output logic               attack_active,
  output logic               hit_start,
  output logic               attack_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STARTUP  = 2'd1,
    ACTIVE   = 2'd2,
    RECOVERY = 2'd3
  } state_t;

  // Elaboration-time sanity of the per-attack frame tables
  if (NUM_ATK < 1 || NUM_ATK > 7) begin : g_bad_num
    $error("player_attack_multi: NUM_ATK must be 1..7");
  end
  for (genvar g = 0; g < NUM_ATK; g++) begin : g_chk
    localparam logic [FRAME_W-1:0] TOT  = ATK_TOTAL[g*FRAME_W +: FRAME_W];
    localparam logic [FRAME_W-1:0] ACTS = ATK_ACT_S[g*FRAME_W +: FRAME_W];
    localparam logic [FRAME_W-1:0] ACTE = ATK_ACT_E[g*FRAME_W +: FRAME_W];
    if (TOT == '0) begin : g_bad_total
      $error("player_attack_multi: attack total must be >= 1");
    end
    if (ACTS > ACTE || ACTE >= TOT) begin : g_bad_window
      $error("player_attack_multi: active window must satisfy ACT_S <= ACT_E < TOTAL");
    end
  end

  function automatic logic [TYPE_W-1:0] lowest_idx(input logic [NUM_ATK-1:0] v);
    lowest_idx = '0;
    for (int i = int'(NUM_ATK) - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = TYPE_W'(i);
    end
  endfunction

  function automatic logic [FRAME_W-1:0] fld_of(input logic [NUM_ATK*FRAME_W-1:0] p,
                                                input logic [TYPE_W-1:0] k);
    fld_of = '0;
    for (int i = 0; i < int'(NUM_ATK); i++) begin
      if (k == TYPE_W'(i)) fld_of = p[i*FRAME_W +: FRAME_W];
    end
  endfunction

  state_t               state_q, state_d;
  logic [NUM_ATK-1:0]   pend_q, pend_d;
  logic [TYPE_W-1:0]    type_q, type_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 busy_q, busy_d;
  logic                 active_q, active_d;
  logic                 hit_q, hit_d;
  logic                 done_q, done_d;
`ifdef ATK_INPUT_BUFFER_EN
  logic                 buf_v_q, buf_v_d;
  logic [TYPE_W-1:0]    buf_idx_q, buf_idx_d;
`endif

  logic                 tick;
  logic [TYPE_W-1:0]    cur_idx;
  logic [FRAME_W-1:0]   cur_total;
  logic [FRAME_W-1:0]   cur_act_s;
  logic [FRAME_W-1:0]   cur_act_e;
  logic [FRAME_W-1:0]   frame_inc;
  logic                 start_en;
  logic [TYPE_W-1:0]    start_idx;

  assign tick      = SCEN & attack_enable;
  assign cur_idx   = type_q - TYPE_W'(1);
  assign cur_total = fld_of(ATK_TOTAL, cur_idx);
  assign cur_act_s = fld_of(ATK_ACT_S, cur_idx);
  assign cur_act_e = fld_of(ATK_ACT_E, cur_idx);
  assign frame_inc = frame_q + FRAME_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    type_d    = type_q;
    frame_d   = frame_q;
    busy_d    = busy_q;
    active_d  = active_q;
    hit_d     = 1'b0;
    done_d    = 1'b0;
    start_en  = 1'b0;
    start_idx = '0;
`ifdef ATK_INPUT_BUFFER_EN
    buf_v_d   = buf_v_q;
    buf_idx_d = buf_idx_q;
`endif

    if (cancel) begin
      state_d  = IDLE;
      pend_d   = '0;
      type_d   = '0;
      frame_d  = '0;
      busy_d   = 1'b0;
      active_d = 1'b0;
`ifdef ATK_INPUT_BUFFER_EN
      buf_v_d   = 1'b0;
      buf_idx_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          pend_d = pend_q | attack_req;
          if (tick && pend_d != '0) begin
            start_en  = 1'b1;
            start_idx = lowest_idx(pend_d);
            pend_d    = '0;
          end
        end
        default: begin
`ifdef ATK_INPUT_BUFFER_EN
          // First recovery press is held; later ones are dropped
          if (state_q == RECOVERY && !buf_v_q && attack_req != '0) begin
            buf_v_d   = 1'b1;
            buf_idx_d = lowest_idx(attack_req);
          end
`endif
          if (tick) begin
            if (frame_q == FRAME_W'(cur_total - FRAME_W'(1))) begin
              done_d   = 1'b1;
              state_d  = IDLE;
              type_d   = '0;
              frame_d  = '0;
              busy_d   = 1'b0;
              active_d = 1'b0;
`ifdef ATK_INPUT_BUFFER_EN
              if (buf_v_d) begin
                start_en  = 1'b1;
                start_idx = buf_idx_d;
                buf_v_d   = 1'b0;
                buf_idx_d = '0;
              end
`endif
            end else begin
              frame_d = frame_inc;
              case (state_q)
                STARTUP: begin
                  if (frame_inc == cur_act_s) begin
                    state_d  = ACTIVE;
                    active_d = 1'b1;
                    hit_d    = 1'b1;
                  end
                end
                ACTIVE: begin
                  if (frame_inc > cur_act_e) begin
                    state_d  = RECOVERY;
                    active_d = 1'b0;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end

    // Common attack launch path, shared by idle start and buffered chain
    if (start_en) begin
      type_d  = start_idx + TYPE_W'(1);
      frame_d = '0;
      busy_d  = 1'b1;
      if (fld_of(ATK_ACT_S, start_idx) == '0) begin
        state_d  = ACTIVE;
        active_d = 1'b1;
        hit_d    = 1'b1;
      end else begin
        state_d  = STARTUP;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      type_q    <= '0;
      frame_q   <= '0;
      busy_q    <= 1'b0;
      active_q  <= 1'b0;
      hit_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef ATK_INPUT_BUFFER_EN
      buf_v_q   <= 1'b0;
      buf_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      type_q    <= type_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      active_q  <= active_d;
      hit_q     <= hit_d;
      done_q    <= done_d;
`ifdef ATK_INPUT_BUFFER_EN
      buf_v_q   <= buf_v_d;
      buf_idx_q <= buf_idx_d;
`endif
    end
  end

  assign attack_type   = type_q;
  assign attack_frame  = frame_q;
  assign attack_busy   = busy_q;
  assign attack_active = active_q;
  assign hit_start     = hit_q;
  assign attack_done   = done_q;

endmodule

// File: tb/tb_player_attack_multi.sv
// Scoreboard bench for player_attack_multi: pulse events are queued by stimulus and checked by a monitor.
module tb_player_attack_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       SCEN;
  logic       attack_enable;
  logic [1:0] attack_req;
  logic       cancel;
  logic [1:0] attack_type;
  logic [5:0] attack_frame;
  logic       attack_busy;
  logic       attack_active;
  logic       hit_start;
  logic       attack_done;

  player_attack_multi dut (
    .clk          (clk),
    .reset        (reset),
    .SCEN         (SCEN),
    .attack_enable(attack_enable),
    .attack_req   (attack_req),
    .cancel       (cancel),
    .attack_type  (attack_type),
    .attack_frame (attack_frame),
    .attack_busy  (attack_busy),
    .attack_active(attack_active),
    .hit_start    (hit_start),
    .attack_done  (attack_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  // Entry = {kind (0 hit_start, 1 attack_done), type, frame, busy, active}
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] mk(input int t, input int f, input int b, input int a);
    return {2'(t), 6'(f), 1'(b), 1'(a)};
  endfunction

  function logic [9:0] snap();
    return {attack_type, attack_frame, attack_busy, attack_active};
  endfunction

  task automatic push_ev(input logic kind, input logic [9:0] s);
    exp_q.push_back({kind, s});
  endtask

  task automatic pop_ev(input logic kind);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_pulse: got kind=%0d state=%0h expected no pulse", kind, snap());
    end else begin
      e = exp_q.pop_front();
      check("event", {21'd0, kind, snap()}, {21'd0, e});
    end
  endtask

  // Monitor: every pulse must match the oldest expected event
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (attack_done) pop_ev(1'b1);
        if (hit_start)   pop_ev(1'b0);
      end
    end
  end

  task automatic frame();
    repeat (3) @(negedge clk);
    SCEN = 1'b1;
    @(negedge clk);
    SCEN = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) frame();
  endtask

  task automatic press(input logic [1:0] v);
    @(negedge clk);
    attack_req = v;
    @(negedge clk);
    attack_req = 2'b00;
  endtask

  initial begin
    int f, b, a, ty;
    reset = 1'b0; SCEN = 1'b0; attack_enable = 1'b1; attack_req = 2'b00; cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});
    check("reset_pulses", {30'd0, hit_start, attack_done}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: attack 0 full run, checked frame by frame
    push_ev(1'b0, mk(1, 4, 1, 1));
    push_ev(1'b1, mk(0, 0, 0, 0));
    press(2'b01);
    for (int t = 1; t <= 19; t++) begin
      frame();
      b  = (t <= 18) ? 1 : 0;
      f  = (t <= 18) ? t - 1 : 0;
      a  = (b == 1 && f >= 4 && f <= 10) ? 1 : 0;
      ty = b;
      check($sformatf("t1_tick%0d", t), {22'd0, snap()}, {22'd0, mk(ty, f, b, a)});
    end

    // 2: both buttons pressed on the tick clk; attack 0 wins, attack 1 never starts
    push_ev(1'b0, mk(1, 4, 1, 1));
    push_ev(1'b1, mk(0, 0, 0, 0));
    repeat (3) @(negedge clk);
    attack_req = 2'b11; SCEN = 1'b1;
    @(negedge clk);
    attack_req = 2'b00; SCEN = 1'b0;
    check("t2_start", {22'd0, snap()}, {22'd0, mk(1, 0, 1, 0)});
    run(18);
    check("t2_done", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});
    run(3);
    check("t2_no_second", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});

    // 3: attack 1 cancelled at frame 12, then a normal attack 0
    push_ev(1'b0, mk(2, 8, 1, 1));
    press(2'b10);
    run(13);
    check("t3_frame12", {22'd0, snap()}, {22'd0, mk(2, 12, 1, 1)});
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    check("t3_cancel", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});
    run(3);
    check("t3_idle", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});
    push_ev(1'b0, mk(1, 4, 1, 1));
    push_ev(1'b1, mk(0, 0, 0, 0));
    press(2'b01);
    run(1);
    check("t3_restart", {22'd0, snap()}, {22'd0, mk(1, 0, 1, 0)});
    run(18);
    check("t3_done", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});

    // 4: enable low for 10 frame ticks while active at frame 6
    push_ev(1'b0, mk(1, 4, 1, 1));
    push_ev(1'b1, mk(0, 0, 0, 0));
    press(2'b01);
    run(7);
    check("t4_frame6", {22'd0, snap()}, {22'd0, mk(1, 6, 1, 1)});
    attack_enable = 1'b0;
    run(10);
    check("t4_frozen", {22'd0, snap()}, {22'd0, mk(1, 6, 1, 1)});
    attack_enable = 1'b1;
    run(1);
    check("t4_resume", {22'd0, snap()}, {22'd0, mk(1, 7, 1, 1)});
    run(11);
    check("t4_done", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});

    // 5: press attack 1 during attack 0 recovery
    push_ev(1'b0, mk(1, 4, 1, 1));
    press(2'b01);
    run(15);
    check("t5_recovery", {22'd0, snap()}, {22'd0, mk(1, 14, 1, 0)});
    press(2'b10);
`ifdef ATK_INPUT_BUFFER_EN
    push_ev(1'b1, mk(2, 0, 1, 0));
    push_ev(1'b0, mk(2, 8, 1, 1));
    push_ev(1'b1, mk(0, 0, 0, 0));
    run(4);
    check("t5_chain", {22'd0, snap()}, {22'd0, mk(2, 0, 1, 0)});
    run(26);
    check("t5_chain_done", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});
`else
    push_ev(1'b1, mk(0, 0, 0, 0));
    run(4);
    check("t5_done", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});
    run(3);
    check("t5_discarded", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});
`endif

    // 6: asynchronous reset mid-active
    push_ev(1'b0, mk(1, 4, 1, 1));
    press(2'b01);
    run(6);
    check("t6_active", {22'd0, snap()}, {22'd0, mk(1, 5, 1, 1)});
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_async", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});
    check("t6_async_pulses", {30'd0, hit_start, attack_done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run(4);
    check("t6_after", {22'd0, snap()}, {22'd0, mk(0, 0, 0, 0)});

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
